sae_out_collector: RTL and testbench
====================================

Name: sae_out_collector

Overview:
- Downstream stage of the sae encrypt/decrypt core; consumes its per-character result stream (data_output, output_ready, error flags).
- Buffers results in an 8-entry FIFO and presents them to a host through a valid/ready handshake.
- Keeps sticky error and overflow status plus a count of delivered characters, so host back-pressure never stalls or loses sae results silently.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2
CNT_W, 16, width of the delivered-character counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous reset, active-high (asserted when 1)
sae_data  in  8  character from sae data_output
sae_ready  in  2  sae output_ready: 00 none, 01 ciphertext char, 10 plaintext char, 11 reserved
sae_err_ptxt  in  1  sae err_invalid_ptxt_char
sae_err_key  in  1  sae err_invalid_seckey
sae_err_ctxt  in  1  sae err_invalid_ctxt_char
out_data  out  8  buffered character (FIFO head)
out_tag  out  2  tag of head entry (01 ciphertext, 10 plaintext)
out_valid  out  1  head entry available
out_ready  in  1  host accepts head when out_valid and out_ready are both 1
err_status  out  3  sticky {key, ctxt, ptxt} error flags
overflow  out  1  sticky: a result was dropped because the FIFO was full
clr_status  in  1  synchronous one-cycle clear of err_status and overflow
fill  out  log2(DEPTH)+1  current FIFO occupancy
char_count  out  CNT_W  characters delivered to host since reset

Behaviour:
- Reset (asynchronous, any time including mid-transfer): FIFO empties, pointers = 0, out_valid = 0, out_data = 0, out_tag = 0, err_status = 0, overflow = 0, fill = 0, char_count = 0.
- Write event: sae_ready is 01 or 10 on a rising edge. The entry {sae_ready, sae_data} is pushed. Codes 00 and 11 never push.
- Read event: out_valid and out_ready both 1 on a rising edge. The head entry is popped and char_count increments by 1. char_count wraps from all-ones to 0 with no flag.
- Latency: a pushed entry into an empty FIFO gives out_valid = 1 on the next cycle, with out_data and out_tag showing the entry. The outputs are registered FIFO head, so there is no combinational path from sae_* to out_*.
- out_data and out_tag hold stable while out_valid = 1 and out_ready = 0.
- FIFO states and transitions:
  - EMPTY (fill = 0): a write moves to PARTIAL; a read is impossible because out_valid = 0.
  - PARTIAL: a write only gives fill + 1; a read only gives fill − 1; simultaneous write and read leaves fill unchanged and the data order is preserved.
  - FULL (fill = DEPTH): a write without a read is dropped, overflow is set to 1 and the FIFO is unchanged. A write with a simultaneous read is accepted, fill stays DEPTH and overflow is not set.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. fill is computed from the extra pointer bit or held as a counter; either way it must match the occupancy exactly.
- Error capture:
  - On each edge, err_status[0] |= sae_err_ptxt, err_status[1] |= sae_err_ctxt, err_status[2] |= sae_err_key.
  - Error flags never push an entry, even when they coincide with a nonzero sae_ready; the character is then still pushed normally.
- clr_status = 1 clears err_status and overflow on that edge. A new error or overflow in the same cycle wins, and the flag is 1 after the edge. clr_status never affects FIFO contents or char_count.
- No combinational loops. out_ready may depend combinationally on out_valid in the host without hazard.

Test Plan:
1. Reset, then push 0x41 with tag 01 for one cycle, out_ready = 1 → out_valid = 1 exactly one cycle later with out_data = 0x41 and out_tag = 01; next cycle out_valid = 0 and char_count = 1.
2. Hold out_ready = 0 and push 8 chars 0x61..0x68 with tag 10 → fill = 8; a 9th push of 0x69 → overflow = 1 and fill stays 8. Then release out_ready → the host reads 0x61..0x68 in order, char_count = 8, and 0x69 is never seen.
3. FIFO full, simultaneous push of 0x70 and pop → overflow stays 0, fill stays 8, and 0x70 emerges after the seven remaining entries.
4. Pulse sae_err_key for one cycle with sae_ready = 00 → err_status = 100 and fill unchanged. Pulse clr_status together with sae_err_ptxt → err_status = 001 after that edge.
5. Apply sae_ready = 11 with data 0xFF for 3 cycles → no push, fill = 0, out_valid = 0.
6. Assert rst_n asynchronously (between clock edges) with 5 entries queued and overflow set → all outputs go to 0 immediately, without waiting for a clock edge. After release, push 0x42 → delivered normally and char_count = 1.

Source files
------------

// File: rtl/sae_out_collector.sv
// Result collector behind the sae core: 8-deep FIFO toward a host valid/ready port.
// It also keeps sticky error and overflow flags and a count of delivered characters.
module sae_out_collector #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       sae_data,
  input  logic [1:0]       sae_ready,
  input  logic             sae_err_ptxt,
  input  logic             sae_err_key,
  input  logic             sae_err_ctxt,
  output logic [7:0]       out_data,
  output logic [1:0]       out_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       err_status,
  output logic             overflow,
  input  logic             clr_status,
  output logic [AW:0]      fill,
  output logic [CNT_W-1:0] char_count
);

  logic [DEPTH-1:0][9:0] mem_q, mem_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           fill_q, fill_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            out_data_q, out_data_d;
  logic [1:0]            out_tag_q, out_tag_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            err_q, err_d;
  logic                  ovf_q, ovf_d;

  logic       wr_ev, rd_ev, full, push;
  logic [9:0] entry, head;

  always_comb begin
    wr_ev    = (sae_ready == 2'b01) || (sae_ready == 2'b10);
    rd_ev    = out_valid_q && out_ready;
    full     = (fill_q == (AW+1)'(DEPTH));
    push     = wr_ev && (!full || rd_ev);
    entry    = {sae_ready, sae_data};

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(rd_ev);
    fill_d   = fill_q + (AW+1)'(push) - (AW+1)'(rd_ev);

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = entry;

    // Next head is the slot being written this cycle when the FIFO drains into it.
    head = (push && (rd_ptr_d == wr_ptr_q)) ? entry : mem_q[rd_ptr_d];
    out_valid_d = (fill_d != '0);
    {out_tag_d, out_data_d} = out_valid_d ? head : 10'd0;

    cnt_d = cnt_q + CNT_W'(rd_ev);
    err_d = (clr_status ? 3'b000 : err_q) | {sae_err_key, sae_err_ctxt, sae_err_ptxt};
    ovf_d = (clr_status ? 1'b0 : ovf_q) | (wr_ev && full && !rd_ev);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign out_valid  = out_valid_q;
  assign err_status = err_q;
  assign overflow   = ovf_q;
  assign fill       = fill_q;
  assign char_count = cnt_q;

endmodule

// File: tb/tb_sae_out_collector.sv
// Bench for sae_out_collector: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_sae_out_collector;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] sae_data = '0;
  logic [1:0] sae_ready = '0;
  logic sae_err_ptxt = 0, sae_err_key = 0, sae_err_ctxt = 0;
  logic out_ready = 0, clr_status = 0;
  logic [7:0] out_data;
  logic [1:0] out_tag;
  logic out_valid, overflow;
  logic [2:0] err_status;
  logic [3:0] fill;
  logic [CNT_W-1:0] char_count;

  int passed = 0, total = 0;

  sae_out_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst), .sae_data(sae_data), .sae_ready(sae_ready),
    .sae_err_ptxt(sae_err_ptxt), .sae_err_key(sae_err_key), .sae_err_ctxt(sae_err_ctxt),
    .out_data(out_data), .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready),
    .err_status(err_status), .overflow(overflow), .clr_status(clr_status),
    .fill(fill), .char_count(char_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a queue of {tag,data} entries plus sticky flags.
  logic [9:0] m_q[$];
  logic [2:0] m_err;
  logic m_ovf;
  logic [CNT_W-1:0] m_cnt;

  always @(posedge clk or posedge rst) begin : model
    bit rd, wr;
    int n;
    if (rst) begin
      m_q.delete(); m_err = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      n  = m_q.size();
      rd = (n != 0) && out_ready;
      wr = (sae_ready == 2'd1) || (sae_ready == 2'd2);
      if (rd) begin void'(m_q.pop_front()); m_cnt = m_cnt + 1'b1; end
      if (wr && (n < DEPTH || rd)) m_q.push_back({sae_ready, sae_data});
      m_err = (clr_status ? 3'b0 : m_err) | {sae_err_key, sae_err_ctxt, sae_err_ptxt};
      m_ovf = (clr_status ? 1'b0 : m_ovf) | (wr && n == DEPTH && !rd);
    end
  end

  always @(negedge clk) begin : compare
    logic [9:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 10'd0;
    chk("m_valid", out_valid, m_q.size() != 0);
    chk("m_data", out_data, h[7:0]);
    chk("m_tag", out_tag, h[9:8]);
    chk("m_fill", fill, m_q.size());
    chk("m_err", err_status, m_err);
    chk("m_ovf", overflow, m_ovf);
    chk("m_cnt", char_count, m_cnt);
  end

  task automatic cyc(); @(negedge clk); #1; endtask

  task automatic do_reset();
    rst = 1; #2; rst = 0;
    cyc();
  endtask

  task automatic push(input logic [1:0] tg, input logic [7:0] d);
    sae_ready = tg; sae_data = d; cyc(); sae_ready = 0;
  endtask

  // Drain with out_ready high; record up to n accepted values within a cycle budget.
  task automatic drain(input int n, output logic [7:0] got[$]);
    got.delete();
    out_ready = 1;
    for (int i = 0; i < 30 && got.size() < n; i++) begin
      if (out_valid) got.push_back(out_data);
      cyc();
    end
    out_ready = 0;
  endtask

  logic [7:0] got[$];

  initial begin
    #1 rst = 1; #3 rst = 0;
    cyc();
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill, 0);

    // 1: single char latency
    out_ready = 1;
    sae_ready = 2'b01; sae_data = 8'h41; cyc(); sae_ready = 0;
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 8'h41);
    chk("t1_tag", out_tag, 2'b01);
    cyc();
    chk("t1_valid0", out_valid, 0);
    chk("t1_cnt", char_count, 1);
    out_ready = 0;

    // 2: fill, overflow, ordered drain
    do_reset();
    for (int i = 0; i < 8; i++) push(2'b10, 8'h61 + 8'(i));
    chk("t2_fill8", fill, 8);
    chk("t2_ovf0", overflow, 0);
    push(2'b10, 8'h69);
    chk("t2_ovf", overflow, 1);
    chk("t2_fill_hold", fill, 8);
    drain(8, got);
    chk("t2_n", got.size(), 8);
    for (int i = 0; i < got.size(); i++) chk("t2_order", got[i], 8'h61 + 8'(i));
    cyc();
    chk("t2_empty", out_valid, 0);
    chk("t2_cnt", char_count, 8);

    // 3: full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) push(2'b10, 8'h61 + 8'(i));
    out_ready = 1; push(2'b10, 8'h70); out_ready = 0;
    chk("t3_fill", fill, 8);
    chk("t3_ovf", overflow, 0);
    chk("t3_head", out_data, 8'h62);
    drain(8, got);
    chk("t3_n", got.size(), 8);
    for (int i = 0; i < got.size(); i++)
      chk("t3_order", got[i], (i == 7) ? 8'h70 : 8'h62 + 8'(i));

    // 4: errors and clear priority
    sae_err_key = 1; cyc(); sae_err_key = 0;
    chk("t4_key", err_status, 3'b100);
    chk("t4_fill", fill, 0);
    clr_status = 1; sae_err_ptxt = 1; cyc(); clr_status = 0; sae_err_ptxt = 0;
    chk("t4_clr", err_status, 3'b001);
    sae_err_ctxt = 1; sae_ready = 2'b01; sae_data = 8'h33; cyc();
    sae_err_ctxt = 0; sae_ready = 0;
    chk("t4_ctxt", err_status, 3'b011);
    chk("t4_push_with_err", fill, 1);
    drain(1, got);

    // 5: reserved code never pushes
    sae_ready = 2'b11; sae_data = 8'hFF;
    repeat (3) cyc();
    sae_ready = 0;
    chk("t5_fill", fill, 0);
    chk("t5_valid", out_valid, 0);

    // 6: asynchronous reset mid-cycle
    for (int i = 0; i < 9; i++) push(2'b01, 8'h80 + 8'(i));
    out_ready = 1; repeat (3) cyc(); out_ready = 0;
    chk("t6_fill5", fill, 5);
    chk("t6_ovf", overflow, 1);
    @(posedge clk); #2; rst = 1; #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_data", out_data, 0);
    chk("t6_async_fill", fill, 0);
    chk("t6_async_ovf", overflow, 0);
    chk("t6_async_err", err_status, 0);
    chk("t6_async_cnt", char_count, 0);
    #1 rst = 0;
    cyc();
    push(2'b01, 8'h42);
    chk("t6_data", out_data, 8'h42);
    drain(1, got);
    chk("t6_n", got.size(), 1);
    chk("t6_cnt", char_count, 1);

    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
